wb_sram: RTL and testbench

// - Parametrised Wishbone B4 classic single-port SRAM slave; successor of the fixed 32-bit memory slave.
// - Adds configurable data width, depth, base address, programmable wait states, byte-lane writes and error reporting.
// - Sits on the CPU data/instruction bus behind the interconnect; one transaction in flight at a time.

---
 rtl/wb_sram_pkg.sv | 17 +
 rtl/wb_sram_if.sv | 33 +++
 rtl/wb_sram_array.sv | 45 ++++
 rtl/wb_sram.sv | 133 +++++++++++++
 tb/tb_wb_sram.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/wb_sram_pkg.sv
// Shared types and helpers for the Wishbone SRAM slave.
// Contents:
//   wb_state_e - slave FSM states
//   sel_width  - number of byte lanes for a given data width
package wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT,
    WB_TERM
  } wb_state_e;

  function automatic int unsigned sel_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/wb_sram_if.sv
// Wishbone B4 classic bus bundle for a single master/slave pair.
// Signal names follow the slave's point of view.
//   cyc_i, stb_i, we_i, adr_i, sel_i, dat_i : master -> slave
//   dat_o, ack_o, err_o, rty_o              : slave -> master
interface wb_sram_if
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                             cyc_i;
  logic                             stb_i;
  logic                             we_i;
  logic [ADDR_WIDTH-1:0]            adr_i;
  logic [sel_width(DATA_WIDTH)-1:0] sel_i;
  logic [DATA_WIDTH-1:0]            dat_i;
  logic [DATA_WIDTH-1:0]            dat_o;
  logic                             ack_o;
  logic                             err_o;
  logic                             rty_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o, rty_o
  );

endinterface

// File: rtl/wb_sram_array.sv
// DEPTH_WORDS x DATA_WIDTH storage with per-byte write enables and a registered read port.
// Contents are not reset.
//   clk_i    : clock
//   wr_en_i  : write the lanes selected by be_i at idx_i
//   rd_en_i  : capture the word at idx_i into rdata_o
//   be_i     : byte-lane enables
//   idx_i    : word index
//   wdata_i  : write data
//   rdata_o  : registered read data, held until the next read
module wb_sram_array
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                             clk_i,
  input  logic                             wr_en_i,
  input  logic                             rd_en_i,
  input  logic [sel_width(DATA_WIDTH)-1:0] be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0]   idx_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic [DATA_WIDTH-1:0]            rdata_o
);

  localparam int unsigned SelW = sel_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < SelW; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (rd_en_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram.sv
// Wishbone B4 classic single-port SRAM slave with programmable wait states and byte-lane writes.
// Define WB_SRAM_ERR_EN to terminate out-of-range or misaligned accesses with err_o; otherwise
// low address bits are ignored, the word index wraps modulo DEPTH_WORDS and every access acks.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active high
//   bus   : Wishbone slave port (cyc/stb/we/adr/sel/dat in, dat/ack/err/rty out)
module wb_sram
  import wb_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned          WAIT_STATES = 0
) (
  input logic       clk_i,
  input logic       rst_i,
  wb_sram_if.slave  bus
);

  localparam int unsigned SelW     = sel_width(DATA_WIDTH);
  localparam int unsigned LsbW     = $clog2(SelW);
  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitLast = 4'(WAIT_STATES);

  wb_state_e             state_q;
  logic [3:0]            cnt_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  term_err_q;
  logic                  term_rd_q;

  logic                  req;
  logic                  commit;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IdxW-1:0]       word_idx;
  logic [DATA_WIDTH-1:0] rdata;

  assign req      = bus.cyc_i & bus.stb_i;
  assign offset   = bus.adr_i - BASE_ADDR;
  assign word_idx = offset[LsbW +: IdxW];

`ifdef WB_SRAM_ERR_EN
  localparam logic [ADDR_WIDTH:0]   MemBytes = (ADDR_WIDTH+1)'(DEPTH_WORDS * SelW);
  localparam logic [ADDR_WIDTH-1:0] LowMask  = ADDR_WIDTH'(SelW - 1);
  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test too.
  assign addr_err = ({1'b0, offset} >= MemBytes) || ((offset & LowMask) != '0);
`else
  logic unused_offset;
  assign unused_offset = ^offset;
  assign addr_err      = 1'b0;
`endif

  // The edge that moves the FSM into TERM is the one that samples the request and touches the array.
  // A termination still visible on ack_q/err_q blocks acceptance, so a master that has not yet
  // dropped stb_i cannot start a second transfer back to back.
  always_comb begin
    commit = 1'b0;
    unique case (state_q)
      WB_IDLE: commit = req && !ack_q && !err_q && (WAIT_STATES == 0);
      WB_WAIT: commit = req && (cnt_q == WaitLast);
      default: commit = 1'b0;
    endcase
    commit = commit && !rst_i;
  end

  wb_sram_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .wr_en_i (commit && bus.we_i && !addr_err),
    .rd_en_i (commit && !bus.we_i && !addr_err),
    .be_i    (bus.sel_i),
    .idx_i   (word_idx),
    .wdata_i (bus.dat_i),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WB_IDLE;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      term_err_q <= 1'b0;
      term_rd_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        WB_IDLE: begin
          if (req && !ack_q && !err_q) begin
            if (WAIT_STATES == 0) begin
              state_q    <= WB_TERM;
              term_err_q <= addr_err;
              term_rd_q  <= !bus.we_i;
            end else begin
              state_q <= WB_WAIT;
              cnt_q   <= 4'd1;
            end
          end
        end
        WB_WAIT: begin
          if (!req) begin
            state_q <= WB_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == WaitLast) begin
            state_q    <= WB_TERM;
            cnt_q      <= '0;
            term_err_q <= addr_err;
            term_rd_q  <= !bus.we_i;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        WB_TERM: begin
          ack_q   <= !term_err_q;
          err_q   <= term_err_q;
          state_q <= WB_IDLE;
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  assign bus.rty_o = 1'b0;
  assign bus.dat_o = (ack_q && term_rd_q) ? rdata : '0;

endmodule

// File: tb/tb_wb_sram.sv
module tb_wb_sram;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  wb_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

  wb_sram #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .DEPTH_WORDS (16), .BASE_ADDR (32'h0), .WAIT_STATES (0)
  ) dut0 (
    .clk_i (clk), .rst_i (rst), .bus (bus0.slave)
  );

  wb_sram #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .DEPTH_WORDS (64), .BASE_ADDR (32'h0), .WAIT_STATES (3)
  ) dut3 (
    .clk_i (clk), .rst_i (rst), .bus (bus3.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (d == 0) begin
      bus0.cyc_i = cyc; bus0.stb_i = stb; bus0.we_i = we;
      bus0.adr_i = adr; bus0.sel_i = sel; bus0.dat_i = dat;
    end else begin
      bus3.cyc_i = cyc; bus3.stb_i = stb; bus3.we_i = we;
      bus3.adr_i = adr; bus3.sel_i = sel; bus3.dat_i = dat;
    end
  endtask

  task automatic get(input int d, output logic a, output logic e, output logic [31:0] x);
    if (d == 0) begin a = bus0.ack_o; e = bus0.err_o; x = bus0.dat_o; end
    else        begin a = bus3.ack_o; e = bus3.err_o; x = bus3.dat_o; end
  endtask

  // One transfer: lat counts edges after the sampling edge until a termination is seen (-1 = none).
  task automatic op(input int d, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                    input logic [31:0] dat, output int lat, output logic got_ack,
                    output logic got_err, output logic [31:0] rdat, output logic tail);
    logic a, e;
    logic [31:0] x;
    lat = -1; got_ack = 1'b0; got_err = 1'b0; rdat = '0; tail = 1'b0;
    @(posedge clk); #1;
    drive(d, 1'b1, 1'b1, we, adr, sel, dat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      get(d, a, e, x);
      if (a || e) begin
        lat = i; got_ack = a; got_err = e; rdat = x;
        break;
      end
    end
    drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    get(d, a, e, x);
    tail = a | e | (|x);
  endtask

  int          lat;
  logic        ga, ge, tl, a, e, seen;
  logic [31:0] rd, x;

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(bus0.ack_o), 32'd0);
    chk("rst_err0", 32'(bus0.err_o), 32'd0);
    chk("rst_rty0", 32'(bus0.rty_o), 32'd0);
    chk("rst_dat0", bus0.dat_o, 32'h0);
    chk("rst_ack3", 32'(bus3.ack_o), 32'd0);
    rst = 1'b0;

    // Zero wait states: full-word write then read back.
    op(0, 1'b1, 32'h0, 4'hF, 32'h01234567, lat, ga, ge, rd, tl);
    chk("w0_lat", 32'(lat), 32'd1);
    chk("w0_ack", 32'(ga), 32'd1);
    chk("w0_err", 32'(ge), 32'd0);
    chk("w0_tail", 32'(tl), 32'd0);
    op(0, 1'b0, 32'h0, 4'hF, 32'h0, lat, ga, ge, rd, tl);
    chk("r0_lat", 32'(lat), 32'd1);
    chk("r0_dat", rd, 32'h01234567);
    chk("r0_tail", 32'(tl), 32'd0);

    // Byte lanes at address 4, including a sel=0 write that must leave the word alone.
    op(0, 1'b1, 32'h4, 4'hF, 32'hFFFFFFFF, lat, ga, ge, rd, tl);
    op(0, 1'b1, 32'h4, 4'b0001, 32'h000000AA, lat, ga, ge, rd, tl);
    op(0, 1'b1, 32'h4, 4'b0100, 32'h00BB0000, lat, ga, ge, rd, tl);
    op(0, 1'b1, 32'h4, 4'b0000, 32'h12345678, lat, ga, ge, rd, tl);
    chk("sel0_ack", 32'(ga), 32'd1);
    op(0, 1'b0, 32'h4, 4'b0001, 32'h0, lat, ga, ge, rd, tl);
    chk("byte_rd", rd, 32'hFFBBFFAA);

    // Three wait states.
    op(3, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D, lat, ga, ge, rd, tl);
    chk("w3_lat", 32'(lat), 32'd4);
    chk("w3_tail", 32'(tl), 32'd0);
    op(3, 1'b0, 32'h8, 4'hF, 32'h0, lat, ga, ge, rd, tl);
    chk("r3_lat", 32'(lat), 32'd4);
    chk("r3_dat", rd, 32'hCAFEF00D);

    // Abort: stb_i seen low at N+2 while waiting.
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b1, 32'h8, 4'hF, 32'h11111111);
    @(posedge clk);
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      get(3, a, e, x);
      seen = seen | a | e;
    end
    chk("abort_noterm", 32'(seen), 32'd0);
    op(3, 1'b0, 32'h8, 4'hF, 32'h0, lat, ga, ge, rd, tl);
    chk("abort_rd", rd, 32'hCAFEF00D);

    // Address range handling with 16 words (64 bytes).
`ifdef WB_SRAM_ERR_EN
    op(0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, lat, ga, ge, rd, tl);
    chk("oor_err", 32'(ge), 32'd1);
    chk("oor_ack", 32'(ga), 32'd0);
    chk("oor_lat", 32'(lat), 32'd1);
    op(0, 1'b1, 32'h2, 4'hF, 32'h5A5A5A5A, lat, ga, ge, rd, tl);
    chk("mis_err", 32'(ge), 32'd1);
    chk("mis_ack", 32'(ga), 32'd0);
    op(0, 1'b0, 32'h40, 4'hF, 32'h0, lat, ga, ge, rd, tl);
    chk("oor_rd_dat", rd, 32'h0);
    op(0, 1'b0, 32'h0, 4'hF, 32'h0, lat, ga, ge, rd, tl);
    chk("err_unch", rd, 32'h01234567);
`else
    op(0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, lat, ga, ge, rd, tl);
    chk("alias_ack", 32'(ga), 32'd1);
    chk("alias_err", 32'(ge), 32'd0);
    op(0, 1'b0, 32'h0, 4'hF, 32'h0, lat, ga, ge, rd, tl);
    chk("alias_rd", rd, 32'hDEADBEEF);
    op(0, 1'b1, 32'h2, 4'hF, 32'h5A5A5A5A, lat, ga, ge, rd, tl);
    chk("lowbits_ack", 32'(ga), 32'd1);
    op(0, 1'b0, 32'h0, 4'hF, 32'h0, lat, ga, ge, rd, tl);
    chk("lowbits_rd", rd, 32'h5A5A5A5A);
`endif

    // Reset during WAIT of a write: no termination, write discarded.
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b1, 1'b1, 32'h8, 4'hF, 32'h22222222);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(3, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_idle", 32'(dut3.state_q), 32'(WB_IDLE));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      get(3, a, e, x);
      seen = seen | a | e;
      @(posedge clk); #1;
    end
    chk("rst_noterm", 32'(seen), 32'd0);
    op(3, 1'b0, 32'h8, 4'hF, 32'h0, lat, ga, ge, rd, tl);
    chk("rst_rd_lat", 32'(lat), 32'd4);
    chk("rst_rd_dat", rd, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
